// File: rtl/ebr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ebr_ctrl_pkg
// Brief  : Shared state encoding and read-latency helper for the EBR port arbiter.
// Rev    : 1.0
// ============================================================================
package ebr_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ebr_state_e;

  // GNT-to-VLD distance: the command register plus the EBR read stage,
  // plus the optional EBR output register.
  function automatic int unsigned read_latency(input string mode);
    return (mode == "OUTREG") ? 32'd3 : 32'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter with combinational grants.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // r_prio = 0 favours requester 0, 1 favours requester 1
  logic r_prio;

  assign gnt0 = en & req0 & (~req1 | ~r_prio);
  assign gnt1 = en & req1 & (~req0 |  r_prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (gnt0) begin
      r_prio <= 1'b1;
    end else if (gnt1) begin
      r_prio <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ebr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ebr_port_arbiter
// Brief  : Shares one EBR port between two requesters, with optional zero-fill.
// Rev    : 1.0
// ============================================================================
module ebr_port_arbiter
  import ebr_ctrl_pkg::*;
#(
  parameter string REGMODE        = "NOREG",
  parameter int    ADDR_W         = 13,
  parameter int    DATA_W         = 9,
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] AD0,
  input  logic [ADDR_W-1:0] AD1,
  input  logic [DATA_W-1:0] DI0,
  input  logic [DATA_W-1:0] DI1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              VLD0,
  output logic              VLD1,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              EBR_CE,
  output logic              EBR_OCE,
  output logic              EBR_WE,
  output logic [ADDR_W-1:0] EBR_AD,
  output logic [DATA_W-1:0] EBR_DI,
  input  logic [DATA_W-1:0] EBR_DO
);

  localparam int unsigned       C_LAT         = read_latency(REGMODE);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR   = '1;
  localparam logic [ADDR_W-1:0] C_ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam ebr_state_e        C_RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  ebr_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_addr, w_init_addr_nxt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= C_RESET_STATE;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    case (r_state)
      ST_INIT: begin
        w_init_addr_nxt = r_init_addr + C_ADDR_ONE;
        if (r_init_addr == C_LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  // Grants are forced low while reset is asserted, even when reset lands in RUN.
  logic w_arb_en, w_gnt0, w_gnt1;
  assign w_arb_en = (r_state == ST_RUN) & RSTN;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RSTN),
    .en    (w_arb_en),
    .req0  (REQ0),
    .req1  (REQ1),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  logic              r_ce, r_we;
  logic [ADDR_W-1:0] r_ad;
  logic [DATA_W-1:0] r_di;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_ce <= 1'b0;
      r_we <= 1'b0;
      r_ad <= '0;
      r_di <= '0;
    end else if (r_state == ST_INIT) begin
      r_ce <= 1'b1;
      r_we <= 1'b1;
      r_ad <= r_init_addr;
      r_di <= '0;
    end else if (w_gnt0) begin
      r_ce <= 1'b1;
      r_we <= WE0;
      r_ad <= AD0;
      r_di <= DI0;
    end else if (w_gnt1) begin
      r_ce <= 1'b1;
      r_we <= WE1;
      r_ad <= AD1;
      r_di <= DI1;
    end else begin
      r_ce <= 1'b0;
      r_we <= 1'b0;
    end
  end

  // Requester tags ride alongside each read so returns are steered in issue order.
  logic             w_push_rd, w_push_id;
  logic [C_LAT-1:0] r_tag_vld, r_tag_id;

  assign w_push_rd = (w_gnt0 & ~WE0) | (w_gnt1 & ~WE1);
  assign w_push_id = w_gnt1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[C_LAT-2:0], w_push_rd};
      r_tag_id  <= {r_tag_id[C_LAT-2:0], w_push_id};
    end
  end

  assign GNT0    = w_gnt0;
  assign GNT1    = w_gnt1;
  assign VLD0    = r_tag_vld[C_LAT-1] & ~r_tag_id[C_LAT-1];
  assign VLD1    = r_tag_vld[C_LAT-1] &  r_tag_id[C_LAT-1];
  assign RDATA   = EBR_DO;
  assign BUSY    = (r_state == ST_INIT);
  assign EBR_CE  = r_ce;
  assign EBR_OCE = (C_LAT > 32'd2);
  assign EBR_WE  = r_we;
  assign EBR_AD  = r_ad;
  assign EBR_DI  = r_di;

endmodule
`default_nettype wire

// File: doc/ebr_port_arbiter.md
EBR_PORT_ARBITER -- requirements
Module: ebr_port_arbiter

Interface
REQ-001 SHALL have parameter REGMODE, default "NOREG", meaning the EBR port output register mode ("NOREG" or "OUTREG").
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the EBR address width.
REQ-003 SHALL have parameter DATA_W, default 9, meaning the EBR data width.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, meaning the EBR is zero-filled after reset when 1.
REQ-005 SHALL use one clock and asynchronous active-low reset: CLK input 1, the sole clock, rising edge; RSTN input 1, asynchronous active-low reset.
REQ-006 SHALL have ports REQ0, REQ1, input, 1 bit each: requester n command request, held until granted.
REQ-007 SHALL have ports WE0, WE1, input, 1 bit each: requester n write (1) or read (0).
REQ-008 SHALL have ports AD0, AD1, input, ADDR_W bits each: requester n address.
REQ-009 SHALL have ports DI0, DI1, input, DATA_W bits each: requester n write data.
REQ-010 SHALL have ports GNT0, GNT1, output, 1 bit each: command accepted this cycle.
REQ-011 SHALL have ports VLD0, VLD1, output, 1 bit each: read data for requester n is valid on RDATA this cycle.
REQ-012 SHALL have port RDATA, output, DATA_W bits: read data return.
REQ-013 SHALL have port BUSY, output, 1 bit: init clear in progress.
REQ-014 SHALL have ports EBR_CE, EBR_OCE, EBR_WE, output, 1 bit each: EBR port controls.
REQ-015 SHALL have ports EBR_AD (ADDR_W) and EBR_DI (DATA_W), output: EBR address and write data.
REQ-016 SHALL have port EBR_DO, input, DATA_W bits: EBR read data.

Function
REQ-017 SHALL use states INIT (zero-fill) and RUN; entered from reset as INIT if CLEAR_ON_RESET=1, else RUN.
REQ-018 In INIT, SHALL issue one write of 0 per cycle to addresses 0..2^ADDR_W-1 ascending, hold GNT0/GNT1 low, hold BUSY high, then enter RUN the cycle after the last address.
REQ-019 In RUN, GNTn SHALL be combinational: at most one GNT per cycle, and only if its REQn=1.
REQ-020 With a single requester, that requester SHALL be granted every cycle it requests.
REQ-021 With both requesters, the one not granted most recently SHALL win; the pointer favours requester 0 after reset.
REQ-022 A granted command SHALL be registered and driven on EBR_* in the next cycle with EBR_CE=1; EBR_CE=0 and EBR_WE=0 in idle cycles.
REQ-023 EBR_OCE SHALL be constant 1 for OUTREG and constant 0 for NOREG.
REQ-024 Read latency from the GNT cycle to the VLDn cycle SHALL be exactly 2 (NOREG) or 3 (OUTREG), with RDATA=EBR_DO combinationally.
REQ-025 A tag shift register SHALL track the requester ID of each in-flight read so returns are in issue order; back-to-back reads sustain 1 per cycle.
REQ-026 Writes SHALL produce no VLD; VLD0 and VLD1 SHALL never both be 1.
REQ-027 A read following a write to the same address in the next cycle SHALL return the new data.

Reset
REQ-028 While RSTN=0: GNTn=0, VLDn=0, BUSY=CLEAR_ON_RESET, EBR_CE=0, EBR_WE=0, EBR_AD=0, EBR_DI=0, tags cleared, priority pointer set to 0, init address set to 0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight reads with no VLD afterwards; reset asserted mid-INIT SHALL restart the clear from address 0.

Structure
REQ-030 Package ebr_ctrl_pkg SHALL hold the state enum and the REGMODE-to-latency constant function.
REQ-031 Two-way round-robin arbitration SHALL be the sub-module rr_arb2.

Verification
REQ-032 Scenario 1: CLEAR_ON_RESET=1, ADDR_W=4, reset release -> 16 writes of 0 to addresses 0..15, BUSY high for 16 cycles, then a read of address 5 returns 0.
REQ-033 Scenario 2: NOREG; REQ0 writes 0x1A5 to address 0x0010 and reads it in the next cycle -> VLD0 two cycles after the read GNT with RDATA=0x1A5.
REQ-034 Scenario 3: REQ0 and REQ1 held high with reads for 6 cycles -> GNT pattern 0,1,0,1,0,1, and VLD pattern matches it after the latency.
REQ-035 Scenario 4: OUTREG, back-to-back reads of addresses 1,2,3 -> three consecutive VLD cycles 3 cycles after each GNT, data in order, EBR_OCE=1.
REQ-036 Scenario 5: RSTN pulsed low while 2 reads are in flight -> no VLD after reset, all outputs at reset values.
REQ-037 Scenario 6: REQ1 only, writes -> GNT1 every cycle, no VLD asserted.
